// File: rtl/sva_trk_pkg.sv
// Shared types and helpers for the obligation tracker: controller states and
// a saturating counter increment.
package sva_trk_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } trk_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        if (value >= max_value) begin
            return max_value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/sva_age_fifo.sv
// Circular FIFO of open obligations; each slot carries an age that can be
// bulk-incremented. The oldest obligation is always at the head.
module sva_age_fifo #(
    parameter int NUM_SLOTS = 4,
    parameter int MAX_DELAY = 4,
    localparam int PTR_W = $clog2(NUM_SLOTS),
    localparam int CNT_W = PTR_W + 1,
    localparam int AGE_W = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             age_en,
    output logic [AGE_W-1:0] head_age,
    output logic [CNT_W-1:0] count
);

    logic [AGE_W-1:0] age_r [NUM_SLOTS];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    // Slot storage, pointers and occupancy; a freshly pushed slot starts at age 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                age_r[i] <= '0;
            end
        end else begin
            if (age_en) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    age_r[i] <= age_r[i] + AGE_W'(1);
                end
            end
            if (push) begin
                age_r[tail_r] <= AGE_W'(1);
                tail_r        <= tail_r + PTR_W'(1);
            end
            if (pop) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_age = age_r[head_r];
    assign count    = count_r;

endmodule

// File: rtl/sva_obligation_tracker.sv
// Bookkeeping controller for antecedent |-> ##[1:MAX_DELAY] consequent:
// opens, discharges, times out and end-of-test resolves obligations.
module sva_obligation_tracker
    import sva_trk_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int MAX_DELAY = 4,
    parameter int CNT_W     = 16,
    localparam int PEND_W   = $clog2(NUM_SLOTS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              antecedent,
    input  logic              consequent,
    input  logic              strong_mode,
    input  logic              end_of_test,
    output logic              pass_pulse,
    output logic              fail_pulse,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic              eot_done
);

    localparam int AGE_W = $clog2(MAX_DELAY + 1);
    localparam logic [PEND_W-1:0] SLOTS_C   = PEND_W'(NUM_SLOTS);
    localparam logic [AGE_W-1:0]  MAX_C     = AGE_W'(MAX_DELAY);
    localparam logic [31:0]       CNT_MAX_C = 32'({CNT_W{1'b1}});

    trk_state_e        state_r;
    trk_state_e        state_nxt_s;
    logic              strong_r;
    logic              push_s;
    logic              pop_s;
    logic              age_en_s;
    logic              pass_s;
    logic              fail_s;
    logic              drop_s;
    logic              has_head_s;
    logic [AGE_W-1:0]  head_age_s;
    logic [PEND_W-1:0] count_s;
    logic [PEND_W-1:0] left_s;

    sva_age_fifo #(
        .NUM_SLOTS (NUM_SLOTS),
        .MAX_DELAY (MAX_DELAY)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .pop      (pop_s),
        .age_en   (age_en_s),
        .head_age (head_age_s),
        .count    (count_s)
    );

    assign has_head_s = (count_s != '0);
    assign pending    = count_s;

    // Per-state decision: head check, then aging, then allocation against post-pop room.
    always_comb begin
        push_s      = 1'b0;
        pop_s       = 1'b0;
        age_en_s    = 1'b0;
        pass_s      = 1'b0;
        fail_s      = 1'b0;
        drop_s      = 1'b0;
        left_s      = count_s;
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                age_en_s = 1'b1;
                if (has_head_s && consequent) begin
                    pass_s = 1'b1;
                end else if (has_head_s && (head_age_s == MAX_C)) begin
                    fail_s = 1'b1;
                end else begin
                    pass_s = 1'b0;
                end
                pop_s  = pass_s | fail_s;
                left_s = count_s - PEND_W'(pop_s);
                push_s = antecedent && (left_s != SLOTS_C);
                drop_s = antecedent && (left_s == SLOTS_C);
                if (end_of_test) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                pop_s  = has_head_s;
                fail_s = has_head_s & strong_r;
                left_s = count_s - PEND_W'(pop_s);
                if (left_s == '0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Controller state, registered pulses, saturating counters and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            strong_r   <= 1'b0;
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            overflow   <= 1'b0;
            eot_done   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pass_pulse <= pass_s;
            fail_pulse <= fail_s;
            eot_done   <= (state_nxt_s == ST_DONE);
            if ((state_r == ST_RUN) && end_of_test) begin
                strong_r <= strong_mode;
            end
            if (pass_s) begin
                pass_cnt <= CNT_W'(sat_inc(32'(pass_cnt), CNT_MAX_C));
            end
            if (fail_s) begin
                fail_cnt <= CNT_W'(sat_inc(32'(fail_cnt), CNT_MAX_C));
            end
            if (drop_s) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sva_obligation_tracker.sv
// Directed scoreboard bench: each step queues its expected outputs and the
// queue entry is compared just after the clock edge that produces them.
module tb_sva_obligation_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, antecedent, consequent, strong_mode, end_of_test;
    logic        pass_pulse, fail_pulse, overflow, eot_done;
    logic [15:0] pass_cnt, fail_cnt;
    logic [2:0]  pending;

    logic        b_rst, b_antecedent, b_consequent, b_strong_mode, b_end_of_test;
    logic        b_pass_pulse, b_fail_pulse, b_overflow, b_eot_done;
    logic [1:0]  b_pass_cnt, b_fail_cnt;
    logic [1:0]  b_pending;

    sva_obligation_tracker #(.NUM_SLOTS(4), .MAX_DELAY(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .antecedent(antecedent), .consequent(consequent),
        .strong_mode(strong_mode), .end_of_test(end_of_test),
        .pass_pulse(pass_pulse), .fail_pulse(fail_pulse), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .pending(pending), .overflow(overflow), .eot_done(eot_done)
    );

    // Small variant: two slots force overflow, two-bit counters show saturation.
    sva_obligation_tracker #(.NUM_SLOTS(2), .MAX_DELAY(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .antecedent(b_antecedent), .consequent(b_consequent),
        .strong_mode(b_strong_mode), .end_of_test(b_end_of_test),
        .pass_pulse(b_pass_pulse), .fail_pulse(b_fail_pulse), .pass_cnt(b_pass_cnt),
        .fail_cnt(b_fail_cnt), .pending(b_pending), .overflow(b_overflow), .eot_done(b_eot_done)
    );

    typedef struct {
        string tag;
        int    pp, fp, pc, fc, pend, ov, eot;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   sel_b  = 1'b0;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic r, a, c, s, e,
                       input int xpp, xfp, xpc, xfc, xpend, xov, xeot);
        exp_t x;
        if (!sel_b) begin
            rst = r; antecedent = a; consequent = c; strong_mode = s; end_of_test = e;
        end else begin
            b_rst = r; b_antecedent = a; b_consequent = c; b_strong_mode = s; b_end_of_test = e;
        end
        x.tag = tag; x.pp = xpp; x.fp = xfp; x.pc = xpc; x.fc = xfc;
        x.pend = xpend; x.ov = xov; x.eot = xeot;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        if (!sel_b) begin
            chk(x.tag, "pass_pulse", 32'(pass_pulse), x.pp);
            chk(x.tag, "fail_pulse", 32'(fail_pulse), x.fp);
            chk(x.tag, "pass_cnt",   32'(pass_cnt),   x.pc);
            chk(x.tag, "fail_cnt",   32'(fail_cnt),   x.fc);
            chk(x.tag, "pending",    32'(pending),    x.pend);
            chk(x.tag, "overflow",   32'(overflow),   x.ov);
            chk(x.tag, "eot_done",   32'(eot_done),   x.eot);
        end else begin
            chk(x.tag, "pass_pulse", 32'(b_pass_pulse), x.pp);
            chk(x.tag, "fail_pulse", 32'(b_fail_pulse), x.fp);
            chk(x.tag, "pass_cnt",   32'(b_pass_cnt),   x.pc);
            chk(x.tag, "fail_cnt",   32'(b_fail_cnt),   x.fc);
            chk(x.tag, "pending",    32'(b_pending),    x.pend);
            chk(x.tag, "overflow",   32'(b_overflow),   x.ov);
            chk(x.tag, "eot_done",   32'(b_eot_done),   x.eot);
        end
    endtask

    initial begin
        b_rst = 1'b1; b_antecedent = 1'b0; b_consequent = 1'b0;
        b_strong_mode = 1'b0; b_end_of_test = 1'b0;

        //          tag          r a c s e   pp fp pc fc pend ov eot
        cyc("reset",      1,0,0,0,0, 0,0,0,0,0,0,0);
        cyc("idle",       0,0,0,0,0, 0,0,0,0,0,0,0);
        // discharge two cycles after the antecedent
        cyc("pass_ant",   0,1,0,0,0, 0,0,0,0,1,0,0);
        cyc("pass_wait",  0,0,0,0,0, 0,0,0,0,1,0,0);
        cyc("pass_con",   0,0,1,0,0, 1,0,1,0,0,0,0);
        cyc("pass_after", 0,0,0,0,0, 0,0,1,0,0,0,0);
        // antecedent with consequent on an empty FIFO must not self-discharge
        cyc("same_cyc",   0,1,1,0,0, 0,0,1,0,1,0,0);
        cyc("same_next",  0,0,1,0,0, 1,0,2,0,0,0,0);
        // timeout at age MAX_DELAY
        cyc("to_ant",     0,1,0,0,0, 0,0,2,0,1,0,0);
        for (int i = 0; i < 3; i++) cyc("to_age", 0,0,0,0,0, 0,0,2,0,1,0,0);
        cyc("to_fail",    0,0,0,0,0, 0,1,2,1,0,0,0);
        cyc("to_after",   0,0,0,0,0, 0,0,2,1,0,0,0);
        // consequent exactly at age MAX_DELAY still passes
        cyc("bnd_ant",    0,1,0,0,0, 0,0,2,1,1,0,0);
        for (int i = 0; i < 3; i++) cyc("bnd_age", 0,0,0,0,0, 0,0,2,1,1,0,0);
        cyc("bnd_con",    0,0,1,0,0, 1,0,3,1,0,0,0);
        // fill, then fifth antecedent fits because the head times out on that edge
        for (int i = 0; i < 4; i++) cyc("ord_fill", 0,1,0,0,0, 0,0,3,1,i+1,0,0);
        cyc("ord_5th",    0,1,0,0,0, 0,1,3,2,4,0,0);
        cyc("ord_con",    0,0,1,0,0, 1,0,4,2,3,0,0);
        cyc("ord_to1",    0,0,0,0,0, 0,1,4,3,2,0,0);
        cyc("ord_to2",    0,0,0,0,0, 0,1,4,4,1,0,0);
        cyc("ord_to3",    0,0,0,0,0, 0,1,4,5,0,0,0);
        // strong flush of three open obligations
        for (int i = 0; i < 3; i++) cyc("sf_fill", 0,1,0,1,0, 0,0,4,5,i+1,0,0);
        cyc("sf_eot",     0,0,0,1,1, 0,0,4,5,3,0,0);
        cyc("sf_f1",      0,0,0,1,0, 0,1,4,6,2,0,0);
        cyc("sf_f2",      0,0,0,1,0, 0,1,4,7,1,0,0);
        cyc("sf_f3",      0,0,0,1,0, 0,1,4,8,0,0,1);
        cyc("done_hold",  0,1,1,1,1, 0,0,4,8,0,0,1);
        // weak flush; antecedent on the end_of_test edge is still accepted
        cyc("reset2",     1,0,0,0,0, 0,0,0,0,0,0,0);
        cyc("wf_ant1",    0,1,0,0,0, 0,0,0,0,1,0,0);
        cyc("wf_ant2",    0,1,0,0,0, 0,0,0,0,2,0,0);
        cyc("wf_eot",     0,1,0,0,1, 0,0,0,0,3,0,0);
        cyc("wf_f1",      0,0,1,0,0, 0,0,0,0,2,0,0);
        cyc("wf_f2",      0,1,0,0,0, 0,0,0,0,1,0,0);
        cyc("wf_f3",      0,0,0,0,0, 0,0,0,0,0,0,1);
        // flush with nothing pending lasts one cycle
        cyc("reset3",     1,0,0,0,0, 0,0,0,0,0,0,0);
        cyc("zf_eot",     0,0,0,1,1, 0,0,0,0,0,0,0);
        cyc("zf_done",    0,0,0,1,0, 0,0,0,0,0,0,1);
        // reset in the middle of a strong flush
        cyc("reset4",     1,0,0,0,0, 0,0,0,0,0,0,0);
        cyc("rm_ant1",    0,1,0,1,0, 0,0,0,0,1,0,0);
        cyc("rm_con",     0,0,1,1,0, 1,0,1,0,0,0,0);
        cyc("rm_ant2",    0,1,0,1,0, 0,0,1,0,1,0,0);
        cyc("rm_ant3",    0,1,0,1,0, 0,0,1,0,2,0,0);
        cyc("rm_eot",     0,0,0,1,1, 0,0,1,0,2,0,0);
        cyc("rm_f1",      0,0,0,1,0, 0,1,1,1,1,0,0);
        cyc("rm_rst",     1,0,0,1,0, 0,0,0,0,0,0,0);
        cyc("rm_run",     0,1,0,1,0, 0,0,0,0,1,0,0);

        rst = 1'b1; antecedent = 1'b0;
        sel_b = 1'b1;
        // two-slot variant: overflow, then counter saturation at 3
        cyc("b_reset",    1,0,0,0,0, 0,0,0,0,0,0,0);
        cyc("b_ant1",     0,1,0,0,0, 0,0,0,0,1,0,0);
        cyc("b_ant2",     0,1,0,0,0, 0,0,0,0,2,0,0);
        cyc("b_drop",     0,1,0,0,0, 0,0,0,0,2,1,0);
        cyc("b_age",      0,0,0,0,0, 0,0,0,0,2,1,0);
        cyc("b_to1",      0,0,0,0,0, 0,1,0,1,1,1,0);
        cyc("b_to2",      0,0,0,0,0, 0,1,0,2,0,1,0);
        for (int k = 0; k < 3; k++) begin
            cyc("b_sat_ant", 0,1,0,0,0, 0,0,0,(k == 0) ? 2 : 3,1,1,0);
            for (int i = 0; i < 3; i++) cyc("b_sat_age", 0,0,0,0,0, 0,0,0,(k == 0) ? 2 : 3,1,1,0);
            cyc("b_sat_fail", 0,0,0,0,0, 0,1,0,3,0,1,0);
        end
        cyc("b_rst",      1,0,0,0,0, 0,0,0,0,0,0,0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
